// File: rtl/shiftreg_lr.sv
// Left/right multi-bit shift register with parallel load, IDLE/SHIFT/DONE sequencing.
// Optional rotate mode enabled by defining SHIFTREG_ROTATE_EN (adds port rot).
module shiftreg_lr #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lr,
    input  logic [CNTW-1:0]  count,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
`ifdef SHIFTREG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  dout_reg, dout_next;
    logic              sout_reg, sout_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;
    logic              lr_reg, lr_next;
    logic              fill_bit;
    logic              accept;

    // load wins over start when both are requested in IDLE
    assign accept = (state_reg == ST_IDLE) && start && !load;

`ifdef SHIFTREG_ROTATE_EN
    logic rot_reg, rot_next;

    always_comb begin
        rot_next = rot_reg;
        if (accept) rot_next = rot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rot_reg <= 1'b0;
        else        rot_reg <= rot_next;
    end

    // Rotate feeds back the bit leaving the register instead of sin.
    assign fill_bit = rot_reg ? (lr_reg ? dout_reg[WIDTH-1] : dout_reg[0]) : sin;
`else
    assign fill_bit = sin;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            dout_reg  <= '0;
            sout_reg  <= 1'b0;
            cnt_reg   <= '0;
            lr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            dout_reg  <= dout_next;
            sout_reg  <= sout_next;
            cnt_reg   <= cnt_next;
            lr_reg    <= lr_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = (count == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_reg <= CNTW'(1)) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        dout_next = dout_reg;
        sout_next = sout_reg;
        cnt_next  = cnt_reg;
        lr_next   = lr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    dout_next = din;
                end else if (start) begin
                    cnt_next = count;
                    lr_next  = lr;
                end
            end
            ST_SHIFT: begin
                if (lr_reg) begin
                    dout_next = {dout_reg[WIDTH-2:0], fill_bit};
                    sout_next = dout_reg[WIDTH-1];
                end else begin
                    dout_next = {fill_bit, dout_reg[WIDTH-1:1]};
                    sout_next = dout_reg[0];
                end
                if (cnt_reg != '0) cnt_next = cnt_reg - CNTW'(1);
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_reg == ST_SHIFT);
        done = (state_reg == ST_DONE);
        dout = dout_reg;
        sout = sout_reg;
    end

endmodule

// File: tb/tb_shiftreg_lr.sv
// Directed, table-driven bench for shiftreg_lr (WIDTH=8, CNTW=4 so counts beyond WIDTH are reachable).
module tb_shiftreg_lr;

    localparam int WIDTH = 8;
    localparam int CNTW  = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             lr;
    logic [CNTW-1:0]  count;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic             rot;
    logic [WIDTH-1:0] dout;
    logic             sout;
    logic             busy;
    logic             done;

    int total;
    int bad;

    shiftreg_lr #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .lr    (lr),
        .count (count),
        .load  (load),
        .din   (din),
        .sin   (sin),
`ifdef SHIFTREG_ROTATE_EN
        .rot   (rot),
`endif
        .dout  (dout),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             is_load;
        logic [WIDTH-1:0] din;
        logic             lr;
        logic [CNTW-1:0]  cnt;
        logic             sin;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_sout;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d);
        @(negedge clk);
        load = 1'b1;
        din  = d;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Issue a start and follow it to done; returns the cycle done was seen (41 = never)
    // and the number of busy cycles before it.
    task automatic do_start(input logic l, input logic [CNTW-1:0] c, input logic s,
                            output int done_cyc, output int busy_n);
        @(negedge clk);
        start = 1'b1;
        lr    = l;
        count = c;
        sin   = s;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cyc = 41;
        busy_n   = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int dc;
        int bn;
        int pulses;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        lr    = 1'b0;
        count = '0;
        load  = 1'b0;
        din   = '0;
        sin   = 1'b0;
        rot   = 1'b0;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 4'd0,  1'b0, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 4'd3,  1'b0, 8'h28, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 4'd0,  1'b1, 8'h28, 1'b1};
        vecs[3] = '{1'b1, 8'h81, 1'b0, 4'd0,  1'b0, 8'h81, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 4'd2,  1'b1, 8'hE0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 4'd10, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{1'b1, 8'h3C, 1'b0, 4'd0,  1'b0, 8'h3C, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 4'd1,  1'b0, 8'h1E, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 4'd7,  1'b1, 8'hFE, 1'b0};

        #2;
        chk("reset_dout", int'(dout), 0);
        chk("reset_sout", int'(sout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        $display("txn reset: dout=0x%0h sout=%0b busy=%0b done=%0b", dout, sout, busy, done);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_load) begin
                do_load(vecs[i].din);
                chk($sformatf("v%0d_load_busy", i), int'(busy), 0);
                chk($sformatf("v%0d_load_done", i), int'(done), 0);
            end else begin
                do_start(vecs[i].lr, vecs[i].cnt, vecs[i].sin, dc, bn);
                chk($sformatf("v%0d_latency", i), dc, int'(vecs[i].cnt) + 1);
                chk($sformatf("v%0d_busy_cycles", i), bn, int'(vecs[i].cnt));
            end
            chk($sformatf("v%0d_dout", i), int'(dout), int'(vecs[i].exp_dout));
            chk($sformatf("v%0d_sout", i), int'(sout), int'(vecs[i].exp_sout));
            $display("txn vec %0d: load=%0b lr=%0b cnt=%0d sin=%0b -> dout=0x%0h sout=%0b",
                     i, vecs[i].is_load, vecs[i].lr, vecs[i].cnt, vecs[i].sin, dout, sout);
            if (!vecs[i].is_load) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_done_single", i), int'(done), 0);
            end
        end

        // Hold in IDLE with no command
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold_dout", int'(dout), 8'hFE);
        chk("idle_hold_sout", int'(sout), 0);
        $display("txn idle hold: dout=0x%0h", dout);

        // load and start in the same cycle: load only
        @(negedge clk);
        load  = 1'b1;
        din   = 8'h96;
        start = 1'b1;
        lr    = 1'b1;
        count = 4'd2;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy || done) pulses++;
            @(posedge clk);
            #1;
        end
        chk("ld_st_dout", int'(dout), 8'h96);
        chk("ld_st_no_activity", pulses, 0);
        $display("txn load+start: dout=0x%0h activity=%0d", dout, pulses);

        // start/load during busy are ignored; one done only
        @(negedge clk);
        start = 1'b1;
        lr    = 1'b1;
        count = 4'd3;
        sin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        load  = 1'b1;
        din   = 8'h00;
        lr    = 1'b0;
        count = 4'd9;
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        pulses = 0;
        dc = 0;
        for (int k = 2; k <= 12; k++) begin
            #1;
            if (done) begin
                pulses++;
                if (dc == 0) dc = k;
                chk("busy_ign_dout", int'(dout), 8'hB0);
                chk("busy_ign_sout", int'(sout), 0);
            end
            @(posedge clk);
        end
        chk("busy_ign_latency", dc, 4);
        chk("busy_ign_done_count", pulses, 1);
        $display("txn start during busy: done_cycle=%0d pulses=%0d dout=0x%0h", dc, pulses, dout);

        // async reset mid-shift: abort, no done, then clean command
        @(negedge clk);
        start = 1'b1;
        lr    = 1'b0;
        count = 4'd5;
        sin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_dout", int'(dout), 0);
        chk("abort_sout", int'(sout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        do_load(8'h5A);
        do_start(1'b0, 4'd1, 1'b1, dc, bn);
        chk("post_abort_latency", dc, 2);
        chk("post_abort_dout", int'(dout), 8'hAD);
        chk("post_abort_sout", int'(sout), 0);
        $display("txn reset mid-shift then restart: dout=0x%0h sout=%0b", dout, sout);

`ifdef SHIFTREG_ROTATE_EN
        do_load(8'hA5);
        rot = 1'b1;
        do_start(1'b1, 4'd4, 1'b0, dc, bn);
        rot = 1'b0;
        chk("rot_latency", dc, 5);
        chk("rot_dout", int'(dout), 8'h5A);
        $display("txn rotate: dout=0x%0h done_cycle=%0d", dout, dc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
